// File: rtl/bridge_pkg.sv
// Shared definitions for the multi-slave system bridge.
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - default address map (DM, TIMER0, TIMER1)
//   - pack_map(): packs three 32-bit addresses into the BASE/LIMIT vector
//     layout (slave i in bits [32i+31:32i])
package bridge_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [31:0] DM_BASE      = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT     = 32'h0000_2fff;
  localparam logic [31:0] TIMER0_BASE  = 32'h0000_7f00;
  localparam logic [31:0] TIMER0_LIMIT = 32'h0000_7f0b;
  localparam logic [31:0] TIMER1_BASE  = 32'h0000_7f10;
  localparam logic [31:0] TIMER1_LIMIT = 32'h0000_7f1b;

  function automatic logic [95:0] pack_map(input logic [31:0] s0,
                                           input logic [31:0] s1,
                                           input logic [31:0] s2);
    return {s2, s1, s0};
  endfunction

  localparam logic [95:0] DEF_BASE  = pack_map(DM_BASE, TIMER0_BASE, TIMER1_BASE);
  localparam logic [95:0] DEF_LIMIT = pack_map(DM_LIMIT, TIMER0_LIMIT, TIMER1_LIMIT);

endpackage

// File: rtl/multi_slave_bridge_if.sv
// Bus interfaces of the multi-slave bridge.
//   bridge_cpu_if : CPU data port. master = CPU, slave = bridge.
//     cpu_req/addr/byteen/wdata in, cpu_rdata/ready/err/busy out (bridge view).
//   bridge_slv_if : peripheral side. master = bridge, slave = peripherals.
//     slv_req (one-hot), slv_addr, slv_byteen (per lane), slv_wdata out;
//     slv_rdata (per lane), slv_ready (per lane) in (bridge view).
interface bridge_cpu_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        cpu_busy;

  modport master (output cpu_req, cpu_addr, cpu_byteen, cpu_wdata,
                  input  cpu_rdata, cpu_ready, cpu_err, cpu_busy);
  modport slave  (input  cpu_req, cpu_addr, cpu_byteen, cpu_wdata,
                  output cpu_rdata, cpu_ready, cpu_err, cpu_busy);
endinterface

interface bridge_slv_if #(parameter int NUM_SLAVES = 3);
  logic [NUM_SLAVES-1:0]    slv_req;
  logic [31:0]              slv_addr;
  logic [4*NUM_SLAVES-1:0]  slv_byteen;
  logic [31:0]              slv_wdata;
  logic [32*NUM_SLAVES-1:0] slv_rdata;
  logic [NUM_SLAVES-1:0]    slv_ready;

  modport master (output slv_req, slv_addr, slv_byteen, slv_wdata,
                  input  slv_rdata, slv_ready);
  modport slave  (input  slv_req, slv_addr, slv_byteen, slv_wdata,
                  output slv_rdata, slv_ready);
endinterface

// File: rtl/bridge_addr_decoder.sv
// Combinational address decoder for the bridge.
//   addr : byte address to decode
//   hit  : address falls inside at least one window
//   idx  : index of the matching window (lowest index wins on overlap)
module bridge_addr_decoder #(
  parameter int                       NUM_SLAVES = 3,
  parameter int                       IW         = 2,
  parameter logic [32*NUM_SLAVES-1:0] BASE       = '0,
  parameter logic [32*NUM_SLAVES-1:0] LIMIT      = '0
) (
  input  logic [31:0]   addr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  logic [NUM_SLAVES-1:0] lane_hit;

  // base <= addr <= limit expressed as one unsigned offset compare, which
  // also avoids a constant-true compare when a window starts at 0.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_lane
    localparam logic [31:0] B    = BASE[32*i +: 32];
    localparam logic [31:0] SPAN = LIMIT[32*i +: 32] - B;
    logic [31:0] off;
    assign off         = addr - B;
    assign lane_hit[i] = (off <= SPAN);
  end

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit = |lane_hit;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (lane_hit[i]) idx = IW'(i);
  end

endmodule

// File: rtl/multi_slave_bridge.sv
// Registered bridge between the CPU data port and NUM_SLAVES memory-mapped
// slaves. One outstanding request: decode -> WAIT on the selected slave's
// ready (bounded by TIMEOUT) -> one-cycle RESP with registered data/error.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   cpu   : CPU port (bridge_cpu_if.slave)
//   slv   : slave fan-out (bridge_slv_if.master)
// All slv_* outputs come from latched registers or the state register, so
// there is no combinational path from cpu_* to slv_*.
module multi_slave_bridge
  import bridge_pkg::*;
#(
  parameter int                       NUM_SLAVES = 3,
  parameter logic [32*NUM_SLAVES-1:0] BASE       = DEF_BASE,
  parameter logic [32*NUM_SLAVES-1:0] LIMIT      = DEF_LIMIT,
  parameter int                       TIMEOUT    = 16,
  parameter int                       CW         = 5
) (
  input  logic        clk,
  input  logic        reset,
  bridge_cpu_if.slave cpu,
  bridge_slv_if.master slv
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    byteen_q, byteen_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          dec_hit;
  logic [IW-1:0] dec_idx;
  logic          sel_ready;
  logic [31:0]   sel_rdata;
  logic [NUM_SLAVES-1:0] lane_sel;

  bridge_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .IW         (IW),
    .BASE       (BASE),
    .LIMIT      (LIMIT)
  ) u_dec (
    .addr (cpu.cpu_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Only the latched slave's ready/rdata are looked at; other lanes are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (idx_q == IW'(i)) begin
        sel_ready = slv.slv_ready[i];
        sel_rdata = slv.slv_rdata[32*i +: 32];
      end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    byteen_d = byteen_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (cpu.cpu_req) begin
        if (dec_hit) begin
          idx_d    = dec_idx;
          addr_d   = cpu.cpu_addr;
          wdata_d  = cpu.cpu_wdata;
          byteen_d = cpu.cpu_byteen;
          cnt_d    = '0;
          state_d  = WAIT;
        end else begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      WAIT: begin
        // Ready is tested first so a reply on the threshold cycle still wins.
        if (sel_ready) begin
          rdata_d = (byteen_q == 4'h0) ? sel_rdata : 32'h0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      byteen_q <= byteen_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Lane strobes decode from state_q, so reset drops them asynchronously.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_out
    assign lane_sel[i]                = (state_q == WAIT) && (idx_q == IW'(i));
    assign slv.slv_byteen[4*i +: 4]   = lane_sel[i] ? byteen_q : 4'h0;
  end

  assign slv.slv_req   = lane_sel;
  assign slv.slv_addr  = addr_q;
  assign slv.slv_wdata = wdata_q;

  assign cpu.cpu_rdata = rdata_q;
  assign cpu.cpu_ready = (state_q == RESP);
  assign cpu.cpu_err   = (state_q == RESP) && err_q;
  assign cpu.cpu_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_multi_slave_bridge.sv
// Directed bench for multi_slave_bridge. A schedule-based model predicts,
// per clock cycle, what the CPU- and slave-side outputs must be, from the
// address map and each slave's reply delay; one compare process checks it
// every cycle. A few literal checks pin latencies and data values.
module tb_multi_slave_bridge;

  localparam int NS = 3;
  localparam int TO = 16;

  typedef struct packed {
    logic        busy;
    logic        rdy;
    logic        err;
    logic [2:0]  req;
    logic [11:0] be;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  localparam logic [31:0] MB [NS] = '{32'h0000_0000, 32'h0000_7f00, 32'h0000_7f10};
  localparam logic [31:0] ML [NS] = '{32'h0000_2fff, 32'h0000_7f0b, 32'h0000_7f1b};
  localparam logic [95:0] JUNK = {32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bridge_cpu_if cpu ();
  bridge_slv_if #(.NUM_SLAVES(NS)) slv ();

  multi_slave_bridge dut (
    .clk   (clk),
    .reset (rst_n),
    .cpu   (cpu),
    .slv   (slv)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  exp_t        sched [int];
  logic [31:0] exp_rdata = '0;
  int          req1_cnt = 0;

  // responder state (main process only)
  int          r_idx = -1;
  int          r_rdy = 0;
  int          wcnt = 0;
  logic [2:0]  stale_mask = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (a >= MB[i] && a <= ML[i]) return i;
    return -1;
  endfunction

  // One compare per cycle against the scheduled expectation (idle if none).
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (chk_en) begin
      e = '0;
      if (sched.exists(cyc)) begin
        e = sched[cyc];
        sched.delete(cyc);
      end
      if (e.rdy) exp_rdata = e.rdata;
      if (slv.slv_req[1]) req1_cnt++;
      check("cpu_busy",   cpu.cpu_busy,   e.busy);
      check("cpu_ready",  cpu.cpu_ready,  e.rdy);
      check("slv_req",    slv.slv_req,    e.req);
      check("slv_byteen", slv.slv_byteen, e.be);
      check("cpu_rdata",  cpu.cpu_rdata,  exp_rdata);
      if (e.rdy) check("cpu_err", cpu.cpu_err, e.err);
      if (e.req != 0) begin
        check("slv_addr",  slv.slv_addr,  e.addr);
        check("slv_wdata", slv.slv_wdata, e.wdata);
      end
    end
  end

  // Advance to the next negedge and update the slave responder.
  task automatic tick();
    logic [2:0] rv;
    @(negedge clk);
    if (r_idx >= 0 && slv.slv_req[r_idx]) wcnt++;
    else wcnt = 0;
    rv = stale_mask;
    if (r_idx >= 0 && wcnt != 0 && wcnt == r_rdy) rv[r_idx] = 1'b1;
    slv.slv_ready = rv;
  endtask

  // Present a request from IDLE; rdy = WAIT cycle on which the slave replies
  // (0 = never). Returns at the negedge of the RESP cycle.
  task automatic issue(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                       input int rdy, input logic [31:0] rd_val, input bit hold);
    int sel, w;
    bit tmo;
    exp_t e;
    logic [95:0] rd;
    sel = decode(a);
    cpu.cpu_addr   = a;
    cpu.cpu_byteen = be;
    cpu.cpu_wdata  = wd;
    cpu.cpu_req    = 1'b1;
    r_idx = sel;
    r_rdy = rdy;
    wcnt  = 0;
    rd = JUNK;
    if (sel >= 0) rd[32*sel +: 32] = rd_val;
    slv.slv_rdata = rd;
    tmo = (sel >= 0) && !(rdy >= 1 && rdy <= TO);
    w = (sel < 0) ? 0 : (tmo ? TO : rdy);
    for (int k = 1; k <= w; k++) begin
      e = '0;
      e.busy  = 1'b1;
      e.req   = 3'b001 << sel;
      e.be    = 12'(be) << (4 * sel);
      e.addr  = a;
      e.wdata = wd;
      sched[cyc + k] = e;
    end
    e = '0;
    e.busy  = 1'b1;
    e.rdy   = 1'b1;
    e.err   = (sel < 0) || tmo;
    e.rdata = e.err ? 32'h0 : ((be == 4'h0) ? rd_val : 32'h0);
    sched[cyc + w + 1] = e;
    tick();
    if (!hold) cpu.cpu_req = 1'b0;
    repeat (w) tick();
  endtask

  task automatic txn(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                     input int rdy, input logic [31:0] rd_val);
    issue(a, be, wd, rdy, rd_val, 1'b0);
    tick();
  endtask

  initial begin
    int c0;
    exp_t e;
    cpu.cpu_req = 1'b0; cpu.cpu_addr = '0; cpu.cpu_byteen = '0; cpu.cpu_wdata = '0;
    slv.slv_rdata = '0; slv.slv_ready = '0;

    // reset state
    #2;
    check("rst cpu_ready",  cpu.cpu_ready,  1'b0);
    check("rst cpu_busy",   cpu.cpu_busy,   1'b0);
    check("rst cpu_err",    cpu.cpu_err,    1'b0);
    check("rst cpu_rdata",  cpu.cpu_rdata,  32'h0);
    check("rst slv_req",    slv.slv_req,    3'b000);
    check("rst slv_byteen", slv.slv_byteen, 12'h000);
    check("rst slv_addr",   slv.slv_addr,   32'h0);
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // DM read, zero-wait slave
    c0 = cyc;
    issue(32'h0000_1000, 4'h0, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
    check("dm rd latency", cyc - c0, 2);
    check("dm rd rdata",   cpu.cpu_rdata, 32'hDEAD_BEEF);
    check("dm rd ready",   cpu.cpu_ready, 1'b1);
    tick();

    // write timer1
    txn(32'h0000_7f14, 4'hF, 32'h0000_0005, 1, 32'h1234_5678);
    check("wr rdata zero", cpu.cpu_rdata, 32'h0);

    // unmapped addresses
    c0 = cyc;
    issue(32'h0000_3000, 4'h0, 32'h0, 1, 32'h0, 1'b0);
    check("miss latency", cyc - c0, 1);
    check("miss err",     cpu.cpu_err, 1'b1);
    tick();
    txn(32'h0000_7f0c, 4'h0, 32'h0, 1, 32'h0);
    // window boundaries
    txn(32'h0000_2fff, 4'h0, 32'h0, 1, 32'h0000_2FFF);
    txn(32'h0000_7f0b, 4'h3, 32'hA5A5_0000, 2, 32'h0);
    txn(32'h0000_7f00, 4'h0, 32'h0, 4, 32'h7F00_0001);

    // timeout on slave1
    req1_cnt = 0;
    c0 = cyc;
    issue(32'h0000_7f04, 4'h0, 32'h0, 0, 32'h5555_5555, 1'b0);
    check("tmo latency",  cyc - c0, 17);
    check("tmo req1 cyc", req1_cnt, 16);
    check("tmo err",      cpu.cpu_err, 1'b1);
    tick();
    // ready exactly on the threshold cycle wins
    issue(32'h0000_7f08, 4'h0, 32'h0, TO, 32'h0F0F_0F0F, 1'b0);
    check("thr err",   cpu.cpu_err,   1'b0);
    check("thr rdata", cpu.cpu_rdata, 32'h0F0F_0F0F);
    tick();

    // reset during the third WAIT cycle
    cpu.cpu_addr = 32'h0000_7f04; cpu.cpu_byteen = 4'h0; cpu.cpu_wdata = 32'h0;
    cpu.cpu_req = 1'b1;
    r_idx = 1; r_rdy = 0; wcnt = 0;
    for (int k = 1; k <= 3; k++) begin
      e = '0;
      e.busy = 1'b1; e.req = 3'b010; e.addr = 32'h0000_7f04;
      sched[cyc + k] = e;
    end
    tick();
    cpu.cpu_req = 1'b0;
    tick(); tick();
    #3;
    rst_n = 1'b0;
    chk_en = 1'b0;
    #1;
    check("arst slv_req",   slv.slv_req,   3'b000);
    check("arst cpu_busy",  cpu.cpu_busy,  1'b0);
    check("arst cpu_ready", cpu.cpu_ready, 1'b0);
    check("arst cpu_rdata", cpu.cpu_rdata, 32'h0);
    sched.delete();
    exp_rdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    txn(32'h0000_0040, 4'h0, 32'h0, 1, 32'h0BAD_F00D);

    // back-to-back with cpu_req held through RESP
    issue(32'h0000_7f00, 4'h0, 32'h0, 1, 32'hCAFE_0001, 1'b1);
    tick();
    check("b2b idle busy", cpu.cpu_busy, 1'b0);
    issue(32'h0000_7f00, 4'h0, 32'h0, 1, 32'hCAFE_0002, 1'b0);
    tick();

    // stale ready on a non-selected lane is ignored
    stale_mask = 3'b100;
    slv.slv_ready = stale_mask;
    c0 = cyc;
    issue(32'h0000_1004, 4'h0, 32'h0, 3, 32'h1111_2222, 1'b0);
    check("stale latency", cyc - c0, 4);
    stale_mask = '0;
    tick();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_slave_bridge.md
Name: multi_slave_bridge

Overview:
- Parametrised, registered system bridge between the CPU data port and N memory-mapped slaves (DM, timers, future UART/GPIO).
- Decodes the address against per-slave base/limit windows, routes a single outstanding request to the selected slave, and waits on that slave's ready.
- Returns registered read data, or a bus error on an unmapped address or a slave timeout.
- Sits between the CPU memory stage and the peripheral slaves; replaces the combinational fixed-map bridge.

Parameters:
- NUM_SLAVES, 3, number of slave ports (1..8).
- BASE, {32'h7f10, 32'h7f00, 32'h0}, packed 32*NUM_SLAVES vector of window start addresses; slave i uses bits [32i+31:32i].
- LIMIT, {32'h7f1b, 32'h7f0b, 32'h2fff}, packed inclusive window end addresses, same layout.
- TIMEOUT, 16, wait cycles before a slave is declared dead (>=1).
- CW, 5, timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- cpu_req  input  1  request strobe; sampled only in IDLE.
- cpu_addr  input  32  byte address.
- cpu_byteen  input  4  write byte enables; 4'b0 means read.
- cpu_wdata  input  32  write data.
- cpu_rdata  output  32  registered read data.
- cpu_ready  output  1  one-cycle completion pulse.
- cpu_err  output  1  bus error; qualified by cpu_ready.
- cpu_busy  output  1  high while not in IDLE.
- slv_req  output  NUM_SLAVES  one-hot request to the selected slave.
- slv_addr  output  32  latched address, broadcast to all slaves.
- slv_byteen  output  4*NUM_SLAVES  latched byteen on the selected lane; 0 on all others.
- slv_wdata  output  32  latched write data, broadcast.
- slv_rdata  input  32*NUM_SLAVES  per-slave read data.
- slv_ready  input  NUM_SLAVES  per-slave completion.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - All outputs 0: cpu_rdata, cpu_ready, cpu_err, cpu_busy, slv_req, slv_byteen.
  - Latched addr/wdata/byteen=0; counter=0.
- Decode:
  - hit[i] = BASE_i <= cpu_addr <= LIMIT_i (unsigned, inclusive).
  - Overlapping windows: lowest index wins.
  - No hit: miss.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - cpu_req=1 and hit: latch addr/byteen/wdata and slave index; counter=0; go to WAIT.
  - cpu_req=1 and miss: set err_q=1, rdata_q=0; go to RESP. No slave is touched.
  - cpu_req=0: stay in IDLE.
- WAIT:
  - slv_req[idx]=1; slv_byteen lane idx = latched byteen.
  - slv_ready[idx]=1: capture slv_rdata lane idx (0 for writes); err_q=0; go to RESP.
  - Otherwise counter++. When counter==TIMEOUT-1 and still not ready: err_q=1, rdata_q=0; go to RESP.
  - slv_ready on non-selected lanes is ignored.
- RESP:
  - cpu_ready=1 and cpu_err=err_q for exactly one cycle; cpu_rdata holds the value until the next RESP.
  - Unconditionally return to IDLE.
  - cpu_req in this cycle is ignored; the CPU must re-present the request.
- Latency:
  - Hit with zero-wait slave (ready in the first WAIT cycle): cpu_ready 2 cycles after the request edge.
  - Miss: 1 cycle.
  - Timeout: TIMEOUT+1 cycles.
- Outputs are registered or decoded from state only; there is no combinational path from cpu_* to slv_*.
- Reset mid-WAIT aborts the transfer: slv_req drops asynchronously and no cpu_ready is issued.
- A slave asserting ready in the same cycle as the timeout threshold counts as success (ready has priority).
- cpu_busy = (state != IDLE).

Decomposition:
- Shared package bridge_pkg:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - address-map constants DM_BASE/DM_LIMIT, TIMER0_BASE/LIMIT, TIMER1_BASE/LIMIT;
  - a function packing them into BASE/LIMIT vectors.
- One sub-module, bridge_addr_decoder: purely combinational, parametrised by NUM_SLAVES/BASE/LIMIT, outputs hit flag and encoded index. The FSM, latches and counter stay in the top.

Test Plan:
- Read DM: addr 0x0000_1000, byteen 0; slave0 returns 0xDEADBEEF with ready in the first WAIT cycle -> slv_req=3'b001; cpu_ready 2 cycles later with rdata 0xDEADBEEF, err 0.
- Write timer1: addr 0x7f14, byteen 4'hF, wdata 0x5 -> slv_byteen lane2=4'hF, other lanes 0; slv_wdata 0x5; cpu_ready with err 0, rdata 0.
- Unmapped: addr 0x0000_3000, then 0x7f0c -> no slv_req; cpu_ready 1 cycle later with err 1, rdata 0. Boundaries 0x2fff and 0x7f0b hit.
- Timeout: slave1 never ready, TIMEOUT=16 -> slv_req[1] high for 16 cycles; cpu_ready with err 1 at cycle 17. Repeat with ready at the 16th WAIT cycle -> err 0.
- Reset mid-WAIT: drop reset to 0 during the third wait cycle -> slv_req and cpu_busy 0 immediately; after release the FSM is in IDLE and the next read completes normally.
- Back-to-back: cpu_req held high across RESP -> ignored in RESP, re-accepted in the following IDLE cycle; stale slv_ready on a non-selected lane has no effect.
